// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed dmem: sub-word stores by read-modify-write, loads extended.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error instead of being force-aligned.
module load_store_unit #(
  parameter int WORD_AW = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_r_addr,
  output logic [31:0] dmem_w_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LD_ISSUE  = 3'd1;
  localparam logic [2:0] S_LD_WAIT   = 3'd2;
  localparam logic [2:0] S_RMW_ISSUE = 3'd3;
  localparam logic [2:0] S_RMW_WAIT  = 3'd4;
  localparam logic [2:0] S_ST_WRITE  = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_addr_aligned;
  logic [31:0] w_word_addr;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b010:  load_extend = d;
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    store_merge = m;
  endfunction

  // Request legality, alignment check and natural alignment of the accepted address
  always_comb begin
    w_illegal      = 1'b0;
    w_misalign     = 1'b0;
    w_addr_aligned = req_addr;
    if (req_we) begin
      w_illegal = (req_funct3 > 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end
    case (req_funct3[1:0])
      2'b01: begin
`ifdef MISALIGN_TRAP_EN
        w_misalign = req_addr[0];
`else
        w_misalign = 1'b0;
`endif
        w_addr_aligned = {req_addr[31:1], 1'b0};
      end
      2'b10: begin
`ifdef MISALIGN_TRAP_EN
        w_misalign = (req_addr[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif
        w_addr_aligned = {req_addr[31:2], 2'b00};
      end
      default: w_addr_aligned = req_addr;
    endcase
  end

  // Request sequencer: accept, dmem access, merge/extend, single-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_addr   <= w_addr_aligned;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            if (w_illegal || w_misalign) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else if (!req_we) begin
              r_state <= S_LD_ISSUE;
            end else if (req_funct3 == 3'b010) begin
              r_state <= S_ST_WRITE;
            end else begin
              r_state <= S_RMW_ISSUE;
            end
          end
        end
        S_LD_ISSUE:  r_state <= S_LD_WAIT;
        S_LD_WAIT: begin
          r_rdata <= load_extend(r_funct3, r_addr[1:0], dmem_data_out);
          r_state <= S_RESP;
        end
        S_RMW_ISSUE: r_state <= S_RMW_WAIT;
        S_RMW_WAIT: begin
          r_wdata <= store_merge(r_funct3, r_addr[1:0], dmem_data_out, r_wdata);
          r_state <= S_ST_WRITE;
        end
        S_ST_WRITE:  r_state <= S_RESP;
        S_RESP:      r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign w_word_addr  = {{(32-WORD_AW){1'b0}}, r_addr[WORD_AW+1:2]};
  assign req_ready    = rst_n & (r_state == S_IDLE);
  assign dmem_read    = (r_state == S_LD_ISSUE) | (r_state == S_RMW_ISSUE);
  assign dmem_write   = (r_state == S_ST_WRITE);
  assign dmem_r_addr  = dmem_read  ? w_word_addr : 32'd0;
  assign dmem_w_addr  = dmem_write ? w_word_addr : 32'd0;
  assign dmem_data_in = dmem_write ? r_wdata     : 32'd0;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_rdata   = resp_valid ? r_rdata : 32'd0;
  assign resp_err     = resp_valid & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small behavioural dmem.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dmem_r_addr;
  logic [31:0] dmem_w_addr;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;

  logic [31:0] mem [0:15];
  int          wr_cnt;
  int          rsp_cnt;
  int          errors;
  int          checks;

  load_store_unit #(.WORD_AW(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_r_addr(dmem_r_addr), .dmem_w_addr(dmem_w_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: read data appears the cycle after dmem_read
  always @(posedge clk) begin
    if (dmem_write) begin
      mem[dmem_w_addr[3:0]] <= dmem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (dmem_read) dmem_data_out <= mem[dmem_r_addr[3:0]];
    if (resp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Presents a request for one cycle; returns at the negedge inside c1
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    chk1("ready_before_issue", req_ready, 1'b1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp_waddr, input logic [31:0] exp_data);
    issue(1'b0, f3, addr, 32'd0);
    chk1({tag, "_c1_read"}, dmem_read, 1'b1);
    chk({tag, "_c1_raddr"}, dmem_r_addr, exp_waddr);
    cyc(); cyc();
    chk1({tag, "_c3_valid"}, resp_valid, 1'b1);
    chk({tag, "_c3_rdata"}, resp_rdata, exp_data);
    chk1({tag, "_c3_err"}, resp_err, 1'b0);
    cyc();
  endtask

  initial begin
    int p1, p2, p3, w0, r0;
    errors = 0; checks = 0; wr_cnt = 0; rsp_cnt = 0; dmem_data_out = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    cyc(); cyc();
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_dmem_read", dmem_read, 1'b0);
    chk1("rst_dmem_write", dmem_write, 1'b0);
    rst_n = 1'b1;
    #1 chk1("post_rst_ready", req_ready, 1'b1);
    cyc();

    // SW 0x8 <- 0xDEADBEEF
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    chk1("sw_c1_write", dmem_write, 1'b1);
    chk1("sw_c1_read", dmem_read, 1'b0);
    chk("sw_c1_waddr", dmem_w_addr, 32'd2);
    chk("sw_c1_data", dmem_data_in, 32'hDEADBEEF);
    chk1("sw_c1_resp", resp_valid, 1'b0);
    cyc();
    chk1("sw_c2_resp", resp_valid, 1'b1);
    chk1("sw_c2_err", resp_err, 1'b0);
    chk("sw_c2_rdata", resp_rdata, 32'd0);
    chk1("sw_c2_write", dmem_write, 1'b0);
    cyc();

    // SB 0x9 <- 0x55 over 0xDEADBEEF
    issue(1'b1, 3'b000, 32'h9, 32'h00000055);
    chk1("sb_c1_read", dmem_read, 1'b1);
    chk("sb_c1_raddr", dmem_r_addr, 32'd2);
    chk1("sb_c1_write", dmem_write, 1'b0);
    cyc();
    chk1("sb_c2_read", dmem_read, 1'b0);
    chk1("sb_c2_write", dmem_write, 1'b0);
    cyc();
    chk1("sb_c3_write", dmem_write, 1'b1);
    chk("sb_c3_waddr", dmem_w_addr, 32'd2);
    chk("sb_c3_data", dmem_data_in, 32'hDEAD55EF);
    cyc();
    chk1("sb_c4_resp", resp_valid, 1'b1);
    chk1("sb_c4_err", resp_err, 1'b0);
    cyc();

    // SB 0xB <- 0x80 makes word 2 = 0x80AD55EF
    issue(1'b1, 3'b000, 32'hB, 32'hFFFFFF80);
    cyc(); cyc();
    chk("sb2_c3_data", dmem_data_in, 32'h80AD55EF);
    cyc();
    chk1("sb2_c4_resp", resp_valid, 1'b1);
    cyc();

    do_load("lb_b",  3'b000, 32'hB, 32'd2, 32'hFFFFFF80);
    do_load("lbu_b", 3'b100, 32'hB, 32'd2, 32'h00000080);
    do_load("lh_a",  3'b001, 32'hA, 32'd2, 32'hFFFF80AD);
    do_load("lhu_8", 3'b101, 32'h8, 32'd2, 32'h000055EF);
    do_load("lb_9",  3'b000, 32'h9, 32'd2, 32'h00000055);
    do_load("lw_8",  3'b010, 32'h8, 32'd2, 32'h80AD55EF);

    // SH 0x6 <- 0xA5A5 then misaligned LW at 0x6
    issue(1'b1, 3'b010, 32'h4, 32'h12345678);
    cyc(); cyc();
    issue(1'b1, 3'b001, 32'h6, 32'h0000A5A5);
    cyc(); cyc();
    chk("sh_c3_data", dmem_data_in, 32'hA5A55678);
    cyc(); cyc();
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h6, 32'd0);
    chk1("lw6_c1_resp", resp_valid, 1'b1);
    chk1("lw6_c1_err", resp_err, 1'b1);
    chk1("lw6_c1_read", dmem_read, 1'b0);
    chk("lw6_c1_rdata", resp_rdata, 32'd0);
    cyc();
`else
    do_load("lw_6", 3'b010, 32'h6, 32'd1, 32'hA5A55678);
`endif

    // Illegal load funct3
    issue(1'b0, 3'b011, 32'h8, 32'd0);
    chk1("ill_c1_resp", resp_valid, 1'b1);
    chk1("ill_c1_err", resp_err, 1'b1);
    chk1("ill_c1_read", dmem_read, 1'b0);
    chk("ill_c1_rdata", resp_rdata, 32'd0);
    cyc();

    // Back-to-back loads with req_valid held high
    p1 = -1; p2 = -1; p3 = -1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_valid = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
        else p3 = k;
      end
    end
    req_valid = 1'b0;
    chk("b2b_first", p1, 32'd3);
    chk("b2b_second", p2, 32'd7);
    chk("b2b_third", p3, 32'd11);
    cyc();

    // Reset during RMW_WAIT
    issue(1'b1, 3'b000, 32'h0, 32'h00000011);
    cyc();
    w0 = wr_cnt; r0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_read", dmem_read, 1'b0);
    chk1("mid_rst_write", dmem_write, 1'b0);
    chk1("mid_rst_ready", req_ready, 1'b0);
    chk1("mid_rst_resp", resp_valid, 1'b0);
    chk("mid_rst_waddr", dmem_w_addr, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk1("mid_rst_release_ready", req_ready, 1'b1);
    cyc(); cyc(); cyc(); cyc();
    chk("mid_rst_no_write", wr_cnt, w0);
    chk("mid_rst_no_resp", rsp_cnt, r0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
